// File: rtl/std_div_seq_32_if.sv
// Handshake and data bundle for the sequential divider.
// The master starts operations and supplies operands. The slave returns results and a done strobe.
interface std_div_seq_32_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             done;

  modport master (
    output go, left, right,
    input  out_quotient, out_remainder, done
  );

  modport slave (
    input  go, left, right,
    output out_quotient, out_remainder, done
  );
endinterface

// File: rtl/std_div_seq_32.sv
// Multi-cycle unsigned restoring divider. It performs one quotient bit per cycle, MSB first.
// go in IDLE latches the operands. WIDTH steps run in BUSY. A single DONE cycle then pulses done.
// The result registers load on entry to DONE, so a downstream register using done as its
// write enable captures the result in that same cycle.
module std_div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  std_div_seq_32_if.slave       bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // dvd_q shifts the dividend out at the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] outq_q, outq_d;
  logic [WIDTH-1:0] outr_q, outr_d;

  // One restoring step. The compare is WIDTH+1 bits wide, so the shifted-out remainder MSB is kept.
  // With a zero divisor the compare is always true. The quotient becomes all ones and the
  // remainder simply accumulates the dividend.
  logic [WIDTH:0]   r_prime;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign r_prime = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = (r_prime >= {1'b0, dvs_q});
  assign r_step  = ge ? WIDTH'(r_prime - {1'b0, dvs_q}) : r_prime[WIDTH-1:0];
  assign q_step  = {dvd_q[WIDTH-2:0], ge};

  // Next-state, datapath and result-load logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    outq_d  = outq_q;
    outr_d  = outr_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          dvd_d   = bus.left;
          dvs_d   = bus.right;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dvd_d = q_step;
        rem_d = r_step;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          outq_d  = q_step;
          outr_d  = r_step;
          state_d = DONE;
        end
      end
      DONE: begin
        // go is ignored in this cycle. A still-high go is seen again in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation and clears the results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      outq_q  <= '0;
      outr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      outq_q  <= outq_d;
      outr_q  <= outr_d;
    end
  end

  assign bus.out_quotient  = outq_q;
  assign bus.out_remainder = outr_q;
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_std_div_seq_32.sv
// Directed bench for std_div_seq_32. Cycle 0 is the cycle in which go is first presented.
// Results are expected with done in cycle 33.
module tb_std_div_seq_32;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  std_div_seq_32_if #(.WIDTH(32)) bus ();

  std_div_seq_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single operation: go for one cycle, operands trashed afterwards, results checked at 33 and 40
  task automatic run_op(input logic [31:0] l, input logic [31:0] rr,
                        input logic [31:0] eq, input logic [31:0] er, input string nm);
    int first = -1;
    int n_done = 0;
    @(posedge clk); #1;
    bus.left = l; bus.right = rr; bus.go = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin bus.go = 1'b0; bus.left = 32'hDEAD_BEEF; bus.right = 32'h1234_5678; end
      if (bus.done) begin n_done++; if (first < 0) first = c; end
      if (c == 33) begin
        checks++;
        if (bus.out_quotient !== eq) begin errors++;
          $display("FAIL %s quotient got %h want %h", nm, bus.out_quotient, eq); end
        checks++;
        if (bus.out_remainder !== er) begin errors++;
          $display("FAIL %s remainder got %h want %h", nm, bus.out_remainder, er); end
      end
    end
    checks++;
    if (first != 33 || n_done != 1) begin errors++;
      $display("FAIL %s done_timing first %0d count %0d want 33/1", nm, first, n_done); end
    checks++;
    if (bus.out_quotient !== eq || bus.out_remainder !== er) begin errors++;
      $display("FAIL %s hold got %h/%h want %h/%h", nm, bus.out_quotient, bus.out_remainder, eq, er); end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.go = 1'b0; bus.left = '0; bus.right = '0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.out_quotient !== 32'd0 || bus.out_remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got done %b q %h r %h want 0/0/0", bus.done, bus.out_quotient, bus.out_remainder);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", bus.done); end
    end
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7, 32'd14, 32'd2, "div_100_7");
  endtask

  task automatic test_div_zero();
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "div_by_zero");
  endtask

  task automatic test_boundaries();
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "max_div_1");
    run_op(32'd3, 32'd10, 32'd0, 32'd3, "small_div_big");
  endtask

  // go held high: second op re-samples operands in the IDLE cycle after DONE
  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int n_done = 0;
    logic prev = 1'b0;
    @(posedge clk); #1;
    bus.left = 32'd100; bus.right = 32'd7; bus.go = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin bus.left = 32'd9; bus.right = 32'd3; end
      if (bus.done) begin
        n_done++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
        checks++;
        if (prev) begin errors++; $display("FAIL b2b_consecutive_done at cycle %0d", c); end
      end
      prev = bus.done;
      if (c == 33) begin
        checks++;
        if (bus.out_quotient !== 32'd14 || bus.out_remainder !== 32'd2) begin errors++;
          $display("FAIL b2b_first got %0d/%0d want 14/2", bus.out_quotient, bus.out_remainder); end
      end
      if (c == 67) begin
        bus.go = 1'b0;
        checks++;
        if (bus.out_quotient !== 32'd3 || bus.out_remainder !== 32'd0) begin errors++;
          $display("FAIL b2b_second got %0d/%0d want 3/0", bus.out_quotient, bus.out_remainder); end
      end
    end
    checks++;
    if (d1 != 33 || d2 != 67 || n_done != 2) begin errors++;
      $display("FAIL b2b_timing got %0d,%0d count %0d want 33,67 count 2", d1, d2, n_done); end
  endtask

  // go pulses during BUSY must not disturb the running operation
  task automatic test_go_ignored();
    int first = -1;
    @(posedge clk); #1;
    bus.left = 32'd100; bus.right = 32'd7; bus.go = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.go = 1'b0;
      if (c >= 5 && c <= 20) begin bus.left = 32'd1; bus.right = 32'd1; bus.go = c[0]; end
      if (bus.done && first < 0) first = c;
    end
    checks++;
    if (first != 33) begin errors++; $display("FAIL ignore_done_cycle got %0d want 33", first); end
    checks++;
    if (bus.out_quotient !== 32'd14 || bus.out_remainder !== 32'd2) begin errors++;
      $display("FAIL ignore_result got %0d/%0d want 14/2", bus.out_quotient, bus.out_remainder); end
  endtask

  // Asynchronous reset mid-operation: outputs clear immediately, no done pulse follows
  task automatic test_reset_abort();
    int n_done = 0;
    @(posedge clk); #1;
    bus.left = 32'd100; bus.right = 32'd7; bus.go = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.go = 1'b0;
      if (c == 10) begin
        #3 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_quotient !== 32'd0 || bus.out_remainder !== 32'd0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL abort_clear got q %h r %h done %b want 0/0/0", bus.out_quotient, bus.out_remainder, bus.done);
        end
      end
      if (c == 13) reset = 1'b0;
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", n_done); end
    run_op(32'd8, 32'd2, 32'd4, 32'd0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_go_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
